// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: BITS_PER_CYCLE result bits per clock, registered result.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero skip CALC.
module execute_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic            flush,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out
);
  localparam int B    = BITS_PER_CYCLE;
  localparam int ITER = XLEN / B;
  localparam int CW   = $clog2(ITER + 1);

  if (XLEN % 2 != 0) begin : g_xlen_even_chk
    $error("XLEN must be even");
  end
  if (!(B == 1 || B == 2 || B == 4)) begin : g_bpc_legal_chk
    $error("BITS_PER_CYCLE must be 1, 2 or 4");
  end
  if (XLEN % B != 0) begin : g_bpc_div_chk
    $error("XLEN must be a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            neg_a, neg_b, div_zero;
  logic [XLEN-1:0] hi, lo, b_reg;

  // Operand conditioning for the request currently on the inputs
  logic            a_signed, b_signed, neg_a_in, neg_b_in;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    a_signed = ~op[0] | (op == 3'd1);
    b_signed = op[2] ? ~op[0] : ~op[1];
    neg_a_in = a_signed & rs1_data_in[XLEN-1];
    neg_b_in = b_signed & rs2_data_in[XLEN-1];
    abs_a    = neg_a_in ? -rs1_data_in : rs1_data_in;
    abs_b    = neg_b_in ? -rs2_data_in : rs2_data_in;
  end

  logic            early_hit;
  logic [XLEN-1:0] early_result;
  always_comb begin
    early_hit    = 1'b0;
    early_result = '0;
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2]) begin
      if (rs2_data_in == '0) begin
        early_hit    = 1'b1;
        early_result = op[1] ? rs1_data_in : '1;
      end else if (!op[0] && rs1_data_in == {1'b1, {(XLEN-1){1'b0}}} && rs2_data_in == '1) begin
        early_hit    = 1'b1;
        early_result = op[1] ? '0 : rs1_data_in;
      end
    end else if (rs1_data_in == '0 || rs2_data_in == '0) begin
      early_hit    = 1'b1;
      early_result = '0;
    end
`endif
  end

  // One iteration: shift-add on {hi,lo} for multiply, restoring divide with hi=remainder, lo=quotient
  logic [XLEN+B-1:0] partial;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo, step_hi, step_lo;
  always_comb begin
    partial = {{B{1'b0}}, hi} + ({{B{1'b0}}, b_reg} * {{XLEN{1'b0}}, lo[B-1:0]});
    rem     = {1'b0, hi};
    quo     = lo;
    for (int i = 0; i < B; i++) begin
      rem = {rem[XLEN-1:0], quo[XLEN-1]};
      quo = {quo[XLEN-2:0], 1'b0};
      if (rem >= {1'b0, b_reg}) begin
        rem    = rem - {1'b0, b_reg};
        quo[0] = 1'b1;
      end
    end
    if (op_q[2]) begin
      step_hi = rem[XLEN-1:0];
      step_lo = quo;
    end else begin
      step_hi = partial[XLEN+B-1:B];
      step_lo = {partial[B-1:0], lo[XLEN-1:B]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_result;
  always_comb begin
    prod     = {step_hi, step_lo};
    if (neg_a ^ neg_b) prod = -prod;
    quot_fix = (neg_a ^ neg_b) ? -step_lo : step_lo;
    if (div_zero) quot_fix = '1;
    rem_fix  = neg_a ? -step_hi : step_hi;
    case (op_q)
      3'd0:       final_result = prod[XLEN-1:0];
      3'd4, 3'd5: final_result = quot_fix;
      3'd6, 3'd7: final_result = rem_fix;
      default:    final_result = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = early_hit ? DONE : CALC;
        CALC:    if (count == '0) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      op_q       <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      b_reg      <= '0;
      valid_out  <= 1'b0;
      result_out <= '0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: if (start) begin
            op_q     <= op;
            neg_a    <= neg_a_in;
            neg_b    <= neg_b_in;
            div_zero <= (rs2_data_in == '0);
            hi       <= '0;
            lo       <= abs_a;
            b_reg    <= abs_b;
            count    <= CW'(ITER - 1);
            if (early_hit) begin
              result_out <= early_result;
              valid_out  <= 1'b1;
            end
          end
          CALC: begin
            hi <= step_hi;
            lo <= step_lo;
            if (count == '0) begin
              result_out <= final_result;
              valid_out  <= 1'b1;
            end else begin
              count <= count - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == CALC) || (state == DONE);
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: a BITS_PER_CYCLE=1 instance and a BITS_PER_CYCLE=4 instance.
module tb_execute_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, start4, flush, flush4;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, valid_out, busy4, valid4;
  logic [31:0] result_out, result4;
  int checks   = 0;
  int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT  = 1;
  localparam int SPECIAL_LAT4 = 1;
`else
  localparam int SPECIAL_LAT  = 33;
  localparam int SPECIAL_LAT4 = 9;
`endif

  always #5 clk = ~clk;

  execute_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data_in(rs1), .rs2_data_in(rs2),
    .flush(flush), .busy(busy), .valid_out(valid_out), .result_out(result_out)
  );

  execute_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .rs1_data_in(rs1), .rs2_data_in(rs2),
    .flush(flush4), .busy(busy4), .valid_out(valid4), .result_out(result4)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one cycle; returns in the cycle after the sampling edge
  task automatic issue(input bit sel4, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op  = o;
    rs1 = a;
    rs2 = b;
    if (sel4) start4 = 1'b1;
    else      start  = 1'b1;
    next_cycle();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Waits (bounded) for valid; lat is the cycle index relative to the start cycle, -1 on timeout
  task automatic wait_valid(input bit sel4, input int first_c, output int lat, output logic [31:0] res);
    lat = -1;
    res = 'x;
    for (int c = first_c; c <= 100; c++) begin
      @(negedge clk);
      if (sel4 ? valid4 : valid_out) begin
        lat = c;
        res = sel4 ? result4 : result_out;
        next_cycle();
        break;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; flush = 1'b0; flush4 = 1'b0;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || result_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_bpc1: busy=%b valid=%b result=%h, want 0 0 00000000", busy, valid_out, result_out);
    end
    checks++;
    if (busy4 !== 1'b0 || valid4 !== 1'b0 || result4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_bpc4: busy=%b valid=%b result=%h, want 0 0 00000000", busy4, valid4, result4);
    end
    next_cycle();
  endtask

  task automatic test_mul_latency();
    issue(1'b0, 3'd0, 32'd7, 32'hFFFFFFFD);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c <= 33)) begin
        failures++;
        $display("FAIL mul_busy cycle %0d: got %b want %b", c, busy, (c <= 33));
      end
      checks++;
      if (valid_out !== (c == 33)) begin
        failures++;
        $display("FAIL mul_valid cycle %0d: got %b want %b", c, valid_out, (c == 33));
      end
      if (c == 33) begin
        checks++;
        if (result_out !== 32'hFFFFFFEB) begin
          failures++;
          $display("FAIL mul_result: got %h want ffffffeb", result_out);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_high_products();
    logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, ops[i], as[i], bs[i]);
      wait_valid(1'b0, 1, lat, res);
      checks++;
      if (res !== exp[i] || lat != 33) begin
        failures++;
        $display("FAIL high_product op=%0d: got %h at cycle %0d, want %h at cycle 33", ops[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_division();
    logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
    logic [31:0] as  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9};
    logic [31:0] exp [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, ops[i], as[i], bs[i]);
      wait_valid(1'b0, 1, lat, res);
      checks++;
      if (res !== exp[i] || lat != 33) begin
        failures++;
        $display("FAIL division op=%0d: got %h at cycle %0d, want %h at cycle 33", ops[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [2:0]  ops [7] = '{3'd0, 3'd4, 3'd6, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [31:0] as  [7] = '{32'h0, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd5};
    logic [31:0] bs  [7] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp [7] = '{32'h0, 32'h80000000, 32'h0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, ops[i], as[i], bs[i]);
      wait_valid(1'b0, 1, lat, res);
      checks++;
      if (res !== exp[i] || lat != SPECIAL_LAT) begin
        failures++;
        $display("FAIL special #%0d: got %h at cycle %0d, want %h at cycle %0d", i, res, lat, exp[i], SPECIAL_LAT);
      end
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] res;
    issue(1'b0, 3'd5, 32'd1000, 32'd7);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL flush_early_valid cycle %0d: got %b want 0", c, valid_out);
      end
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy_cycle10: got %b want 1", busy);
    end
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || result_out !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL flush_cycle11: busy=%b valid=%b result=%h, want 0 0 ffffffff", busy, valid_out, result_out);
    end
    issue(1'b0, 3'd5, 32'd9, 32'd3);
    wait_valid(1'b0, 1, lat, res);
    checks++;
    if (res !== 32'd3 || lat != 33) begin
      failures++;
      $display("FAIL restart_after_flush: got %h at cycle %0d, want 00000003 at cycle 33", res, lat);
    end
    flush = 1'b1;
    issue(1'b0, 3'd0, 32'd3, 32'd5);
    flush = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL start_with_flush cycle %0d: busy=%b valid=%b, want 0 0", c, busy, valid_out);
      end
      next_cycle();
    end
  endtask

  task automatic test_rst_mid();
    issue(1'b0, 3'd5, 32'd100, 32'd7);
    repeat (5) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || result_out !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b valid=%b result=%h, want 0 0 00000000", busy, valid_out, result_out);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back_bpc4();
    int lat;
    logic [31:0] res;
    issue(1'b1, 3'd0, 32'h12345678, 32'h10);
    repeat (3) next_cycle();
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start4 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin
      failures++;
      $display("FAIL bpc4_busy_cycle4: got %b want 1", busy4);
    end
    next_cycle();
    start4 = 1'b0;
    wait_valid(1'b1, 5, lat, res);
    checks++;
    if (res !== 32'h23456780 || lat != 9) begin
      failures++;
      $display("FAIL bpc4_mul: got %h at cycle %0d, want 23456780 at cycle 9", res, lat);
    end
    issue(1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(1'b1, 1, lat, res);
    checks++;
    if (res !== 32'hFFFFFFFE || lat != 9) begin
      failures++;
      $display("FAIL bpc4_mulhu: got %h at cycle %0d, want fffffffe at cycle 9", res, lat);
    end
    issue(1'b1, 3'd4, 32'hFFFFFFF9, 32'd2);
    wait_valid(1'b1, 1, lat, res);
    checks++;
    if (res !== 32'hFFFFFFFD || lat != 9) begin
      failures++;
      $display("FAIL bpc4_div: got %h at cycle %0d, want fffffffd at cycle 9", res, lat);
    end
    issue(1'b1, 3'd6, 32'd5, 32'd0);
    wait_valid(1'b1, 1, lat, res);
    checks++;
    if (res !== 32'd5 || lat != SPECIAL_LAT4) begin
      failures++;
      $display("FAIL bpc4_rem_by_zero: got %h at cycle %0d, want 00000005 at cycle %0d", res, lat, SPECIAL_LAT4);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_high_products();
    test_division();
    test_specials();
    test_flush();
    test_rst_mid();
    test_back_to_back_bpc4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
